// File: rtl/arb_pkg.sv
// Shared encodings and sizes for the round-robin grant arbiter.
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        GRANT   = S_GRANT,
        RELEASE = S_RELEASE
    } state_t;

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder, defined for every input code.
module onehot_dec3to8
    import arb_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    // Full case table, so every index maps to exactly one bit.
    always_comb begin
        onehot = 8'h00;
        case (idx)
            3'd0:    onehot = 8'h01;
            3'd1:    onehot = 8'h02;
            3'd2:    onehot = 8'h04;
            3'd3:    onehot = 8'h08;
            3'd4:    onehot = 8'h10;
            3'd5:    onehot = 8'h20;
            3'd6:    onehot = 8'h40;
            default: onehot = 8'h80;
        endcase
    end

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per owner.
// A grant is held while the owner keeps requesting, up to MAX_HOLD cycles
// (0 = unlimited), and every release is followed by one dead RELEASE cycle
// in which the next owner is chosen starting just above the previous one.
// Handshake: req is a level; requester i owns the resource exactly in the
// cycles where gnt[i]=1 and must keep req[i] high to continue owning it.
module rr_grant_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [2:0]       idx_nxt;
    logic [7:0]       gnt_nxt;
    logic             valid_nxt;
    logic             busy_nxt;
    logic [2:0]       win_idx;
    logic [7:0]       win_onehot;
    logic             hold_limit;

    // Search starts at p: rotate req right by p, take the lowest set bit,
    // then add p back so the index wraps modulo 8.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                                 input logic [IDX_W-1:0] p);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        logic [IDX_W-1:0]  pe;
        dbl = {r, r} >> p;
        rot = dbl[NREQ-1:0];
        pe  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) pe = IDX_W'(i);
        end
        return pe + p;
    endfunction

    assign win_idx    = rr_pick(req, ptr);
    assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    onehot_dec3to8 u_dec (
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    // Next-state and next-output logic; IDLE and RELEASE arbitrate alike.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        idx_nxt   = gnt_idx;
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        busy_nxt  = busy;
        case (state)
            GRANT: begin
                if (!req[gnt_idx] || hold_limit) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = 8'h00;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    ptr_nxt   = gnt_idx + 3'd1;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                hold_nxt = '0;
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = win_idx;
                    gnt_nxt   = win_onehot;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 8'h00;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt_idx   <= 3'd0;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_idx   <= idx_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8: one instance with MAX_HOLD=16 and
// one with MAX_HOLD=4, checked against hand-computed grant sequences.
module tb_rr_grant_arbiter8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst16_n, rst4_n;
    logic [7:0] req16, req4;
    logic [7:0] gnt16, gnt4;
    logic [2:0] idx16, idx4;
    logic       valid16, valid4, busy16, busy4;

    rr_grant_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut16 (
        .clk       (clk),
        .rst_n     (rst16_n),
        .req       (req16),
        .gnt       (gnt16),
        .gnt_idx   (idx16),
        .gnt_valid (valid16),
        .busy      (busy16)
    );

    rr_grant_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .req       (req4),
        .gnt       (gnt4),
        .gnt_idx   (idx4),
        .gnt_valid (valid4),
        .busy      (busy4)
    );

    // scoreboard
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver: advance one cycle and sample 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        check("onehot16", {31'b0, $onehot0(gnt16)}, 32'd1);
        check("valid16",  {31'b0, valid16}, {31'b0, |gnt16});
        check("onehot4",  {31'b0, $onehot0(gnt4)}, 32'd1);
        check("valid4",   {31'b0, valid4}, {31'b0, |gnt4});
    endtask

    initial begin
        logic [7:0] e;
        rst16_n = 1'b0;
        rst4_n  = 1'b0;
        req16   = 8'hFF;
        req4    = 8'h00;

        // reset with all requests held
        step();
        step();
        check("rst_gnt",   gnt16, 8'h00);
        check("rst_valid", valid16, 1'b0);
        check("rst_busy",  busy16, 1'b0);
        check("rst_idx",   idx16, 3'd0);
        rst16_n = 1'b1;
        step();
        check("first_gnt",  gnt16, 8'h01);
        check("first_idx",  idx16, 3'd0);
        check("first_busy", busy16, 1'b1);

        // full rotation with req=FF: 16 cycles each, one dead cycle between
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 16; c++) exp_q.push_back(8'h01 << k);
            exp_q.push_back(8'h00);
        end
        exp_q.push_back(8'h01);
        e = exp_q.pop_front();
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check("rotate", gnt16, e);
        end

        // drive ptr to 7 by granting and releasing requester 6
        req16 = 8'h00;
        step();
        check("rel_busy", busy16, 1'b1);
        step();
        check("idle_busy", busy16, 1'b0);
        req16 = 8'h40;
        step();
        check("gnt6", gnt16, 8'h40);
        req16 = 8'h00;
        step();
        step();

        // owner wrap: 7 first, then 0, then 7 again
        req16 = 8'h81;
        step();
        check("wrap7_gnt", gnt16, 8'h80);
        check("wrap7_idx", idx16, 3'd7);
        repeat (15) begin
            step();
            check("wrap7_hold", gnt16, 8'h80);
        end
        step();
        check("wrap_dead", gnt16, 8'h00);
        check("wrap_dead_busy", busy16, 1'b1);
        step();
        check("wrap0_gnt", gnt16, 8'h01);
        repeat (15) begin
            step();
            check("wrap0_hold", gnt16, 8'h01);
        end
        step();
        check("wrap_dead2", gnt16, 8'h00);
        step();
        check("wrap7b_gnt", gnt16, 8'h80);
        check("wrap7b_idx", idx16, 3'd7);

        // early release: requester 2 for 3 cycles
        req16 = 8'h00;
        step();
        step();
        check("pre_idle", busy16, 1'b0);
        req16 = 8'h04;
        step();
        check("early_gnt", gnt16, 8'h04);
        check("early_idx", idx16, 3'd2);
        repeat (2) begin
            step();
            check("early_hold", gnt16, 8'h04);
        end
        req16 = 8'h00;
        step();
        check("early_rel_gnt",  gnt16, 8'h00);
        check("early_rel_busy", busy16, 1'b1);
        check("early_rel_idx",  idx16, 3'd2);
        step();
        check("early_idle_busy", busy16, 1'b0);
        check("early_idle_idx",  idx16, 3'd2);
        repeat (3) step();
        // ptr must now be 3 even after idle cycles
        req16 = 8'h0C;
        step();
        check("ptr3_gnt", gnt16, 8'h08);
        check("ptr3_idx", idx16, 3'd3);

        // async reset mid-grant of requester 4 (ptr=4 at that point)
        req16 = 8'h00;
        step();
        step();
        req16 = 8'h10;
        step();
        check("pre_rst_gnt", gnt16, 8'h10);
        #2;
        rst16_n = 1'b0;
        #1;
        check("arst_gnt",   gnt16, 8'h00);
        check("arst_valid", valid16, 1'b0);
        check("arst_busy",  busy16, 1'b0);
        check("arst_idx",   idx16, 3'd0);
        #1;
        req16   = 8'h12;
        rst16_n = 1'b1;
        step();
        check("post_rst_gnt", gnt16, 8'h02);
        check("post_rst_idx", idx16, 3'd1);

        // sole requester with MAX_HOLD=4: 4 on, 1 off, repeating
        rst4_n = 1'b1;
        req4   = 8'h20;
        for (int r = 0; r < 3; r++) begin
            repeat (4) begin
                step();
                check("hold4_gnt", gnt4, 8'h20);
                check("hold4_idx", idx4, 3'd5);
            end
            step();
            check("hold4_dead", gnt4, 8'h00);
            check("hold4_dead_idx", idx4, 3'd5);
            check("hold4_dead_busy", busy4, 1'b1);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Each arbitration picks one winner and drives it as a registered 3-bit index plus a one-hot grant vector. The one-hot vector comes from a 3-to-8 one-hot decode of the index.
- Sits in front of any shared datapath, such as a bus, memory port or display driver, where a requester holds the resource for a bounded number of cycles.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced release; 0 = unlimited.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  level request; bit i = requester i.
- gnt  output  8  registered one-hot grant; all-zero when no owner.
- gnt_idx  output  3  registered index of current owner; holds last value when gnt_valid=0.
- gnt_valid  output  1  registered; 1 while some requester owns the resource.
- busy  output  1  registered; 1 in GRANT or RELEASE.

Behaviour:
- Reset (async assert; deassert is synchronous to clk):
  - gnt=8'h00, gnt_idx=0, gnt_valid=0, busy=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant clears everything immediately; no release cycle.
- States: IDLE, GRANT, RELEASE.
- Arbitration, performed only in IDLE and RELEASE:
  - Search req from index ptr upward: ptr, ptr+1, ... 7, 0, ... ptr-1, modulo 8. The first asserted bit wins.
  - If req==0, no grant; go to or stay in IDLE.
- Latency: req sampled at edge N produces gnt/gnt_idx/gnt_valid at edge N+1 (one registered cycle).
- Entering GRANT:
  - gnt_idx=winner.
  - gnt = one-hot of winner; gnt[winner]=1 only.
  - gnt_valid=1, busy=1, hold_cnt=0.
- In GRANT, each cycle:
  - Release if req[gnt_idx]==0, or if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - Otherwise hold_cnt increments; other req bits are ignored.
- On release:
  - Next state is RELEASE; gnt=0, gnt_valid=0, busy=1.
  - ptr = gnt_idx+1 mod 8; 7 wraps to 0.
  - hold_cnt=0; gnt_idx keeps the old value.
- RELEASE is exactly one dead cycle and arbitrates like IDLE:
  - Winner found: GRANT at the next edge.
  - No winner: IDLE with busy=0.
- Gap between consecutive grants is always exactly 1 cycle of gnt=0.
- Forced release (hold limit reached while owner still requests):
  - Owner drops to lowest priority via the ptr update.
  - It can be re-granted only if no other req is asserted in RELEASE.
- A continuously requesting owner holds exactly MAX_HOLD cycles of gnt_valid=1.
- MAX_HOLD=1 gives a grant every other cycle at most.
- Owner dropping req on its first GRANT cycle still receives that one grant cycle, then RELEASE.
- req bits changing in the same cycle as a release decision: the new values are seen by RELEASE arbitration the following cycle. There are no combinational paths from req to outputs.
- gnt is always one-hot or zero, never multi-hot. gnt_valid == |gnt at all times.
- IDLE: ptr unchanged. Idle cycles do not rotate priority.

Decomposition:
- Shared package arb_pkg:
  - state encoding localparams S_IDLE=2'd0, S_GRANT=2'd1, S_RELEASE=2'd2.
  - NREQ=8, IDX_W=3.
- Sub-module onehot_dec3to8: combinational 3-bit index to 8-bit one-hot, fully specified for all 8 inputs.
  - Decodes the next-state winner index.
  - Its output is registered into gnt.
- The round-robin priority search is a function inside rr_grant_arbiter8. It rotates req by ptr, does a priority-encode, then adds ptr back mod 8.

Test Plan:
- Reset with req=8'hFF held → gnt=0, gnt_valid=0, busy=0. After release of rst_n, gnt=8'h01, gnt_idx=0 one cycle later.
- MAX_HOLD=16, req=8'hFF constant → grants rotate 0,1,2…7,0. Each grant lasts 16 cycles, separated by 1 zero cycle; period 136 cycles.
- Owner wrap: ptr=7, req=8'h81 → grant 7 first. After its release, grant 0 follows; next again 7.
- Early release: req=8'h04 for 3 cycles then 0 → gnt=8'h04 for 3 cycles, 1 RELEASE cycle, then IDLE with busy=0 and ptr=3.
- Sole requester forced release: MAX_HOLD=4, req=8'h20 constant → gnt=8'h20 for 4 cycles, 0 for 1 cycle, repeating. gnt_idx stays 5.
- Async reset mid-GRANT (gnt=8'h10) → outputs clear without waiting for a clock edge. The first grant after reset uses ptr=0, e.g. req=8'h12 gives grant 1.
